// File: rtl/turbo_len_pkg.sv
// rtl/turbo_len_pkg.sv - shared constants and types for the turbo length/enable path
package turbo_len_pkg;

   localparam int LEN_MODE0 = 128;
   localparam int LEN_MODE1 = 1088;
   localparam int LEN_MODE2 = 4160;

   // Length mode carried in link_id[5:4]
   typedef enum logic [1:0] {
      MODE_128  = 2'b00,
      MODE_1088 = 2'b01,
      MODE_4160 = 2'b10,
      MODE_CFG  = 2'b11
   } len_mode_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/turbo_len_lut.sv
// rtl/turbo_len_lut.sv - combinational link_id/cfg_len to turbo block length
module turbo_len_lut
   import turbo_len_pkg::*;
#(
   parameter int ID_W  = 6,
   parameter int LEN_W = 13
) (
   input  logic [ID_W-1:0]  link_id,
   input  logic [LEN_W-1:0] cfg_len,
   output logic [LEN_W-1:0] len
);

   // Low link_id bits select the link, not the length
   logic link_id_unused;
   assign link_id_unused = ^link_id[3:0];

   always_comb begin
      len = cfg_len;
      case (len_mode_e'(link_id[5:4]))
         MODE_128:  len = LEN_W'(LEN_MODE0);
         MODE_1088: len = LEN_W'(LEN_MODE1);
         MODE_4160: len = LEN_W'(LEN_MODE2);
         default:   len = cfg_len;
      endcase
   end

endmodule

// File: rtl/turbo_len_mlane.sv
// rtl/turbo_len_mlane.sv - multi-lane turbo length/enable generator with one-deep pending frame
module turbo_len_mlane
   import turbo_len_pkg::*;
#(
   parameter int LANES = 16,
   parameter int ID_W  = 6,
   parameter int LEN_W = 13,
   parameter int OFF_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din_vld,
   input  logic [ID_W-1:0]  link_id,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             request,
   output logic [LANES-1:0] enable,
   output logic [OFF_W-1:0] id_offset,
   output logic             wen,
   output logic             dout_vld,
   output logic             busy,
   output logic             ovf_err
);

   localparam int               LW       = $clog2(LANES);
   localparam logic [LEN_W-1:0] LANES_L  = LEN_W'(LANES);
   localparam logic [OFF_W-1:0] OFF_STEP = OFF_W'(LANES);

   state_e             state;
   logic [LEN_W-1:0]   rem_r;
   logic [OFF_W-1:0]   off_r;
   logic               pend_v;
   logic [LEN_W-1:0]   pend_len;
   logic [LEN_W-1:0]   lut_len;

   turbo_len_lut #(
      .ID_W  (ID_W),
      .LEN_W (LEN_W)
   ) u_lut (
      .link_id (link_id),
      .cfg_len (cfg_len),
      .len     (lut_len)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rem_r     <= '0;
         off_r     <= '0;
         pend_v    <= 1'b0;
         pend_len  <= '0;
         enable    <= '0;
         id_offset <= '0;
         wen       <= 1'b0;
         dout_vld  <= 1'b0;
         busy      <= 1'b0;
         ovf_err   <= 1'b0;
      end else begin
         wen      <= 1'b0;
         dout_vld <= 1'b0;
         case (state)
            IDLE: begin
               if (din_vld) begin
                  state <= RUN;
                  rem_r <= lut_len;
                  off_r <= '0;
                  busy  <= 1'b1;
               end
            end
            RUN: begin
               if (rem_r == '0) begin
                  // Frame complete: chain the pending frame (or a fresh descriptor) without a bubble
                  dout_vld <= 1'b1;
                  off_r    <= '0;
                  if (pend_v) begin
                     rem_r <= pend_len;
                     if (din_vld)
                        pend_len <= lut_len;
                     else
                        pend_v <= 1'b0;
                  end else if (din_vld) begin
                     rem_r <= lut_len;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  if (request) begin
                     wen       <= 1'b1;
                     id_offset <= off_r;
                     enable    <= (rem_r >= LANES_L) ? {LANES{1'b1}}
                                                     : ~({LANES{1'b1}} << rem_r[LW-1:0]);
                     off_r     <= off_r + OFF_STEP;
                     rem_r     <= (rem_r > LANES_L) ? (rem_r - LANES_L) : '0;
                  end
                  if (din_vld) begin
                     if (pend_v) begin
                        ovf_err <= 1'b1;
                     end else begin
                        pend_v   <= 1'b1;
                        pend_len <= lut_len;
                     end
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: doc/turbo_len_mlane.md
Name: turbo_len_mlane

Overview:
- Parametrised successor of the turbo length/enable generator in the ASM interleaver path.
- Maps a link ID to a turbo block length in bits, or takes a programmed length, then emits one LANES-wide lane-enable mask per request.
- Each mask comes with a write strobe and a bit-offset, so the interleaver memory can be written LANES bits per beat.
- Adds what the previous block lacks: lane-count/width parameters, a programmable-length mode, a one-deep pending-frame slot for back-to-back frames, busy status and an overflow flag.

Parameters:
- LANES, 16, bits per beat and width of enable; power of two, 2..64
- ID_W, 6, link_id width
- LEN_W, 13, block length width in bits; 4160 max must fit
- OFF_W, 16, id_offset width; must be at least LEN_W

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- din_vld  in  1  one-cycle pulse: new frame descriptor on link_id/cfg_len
- link_id  in  ID_W  frame link ID, sampled when din_vld=1
- cfg_len  in  LEN_W  programmed length, used only when link_id[5:4]==2'b11
- request  in  1  downstream asks for the next beat
- enable  out  LANES  lane mask for the current beat; bit i = lane i valid
- id_offset  out  OFF_W  bit index of lane 0 for the current beat
- wen  out  1  beat strobe; enable and id_offset are valid when wen=1
- dout_vld  out  1  one-cycle pulse: frame complete
- busy  out  1  frame active or frame pending
- ovf_err  out  1  sticky; a descriptor was dropped

Behaviour:
- Reset (rst=1 at a clk edge): every output is 0, state is IDLE, pending slot is cleared, ovf_err is cleared. Reset wins over all other inputs, including in the middle of a frame; a partial frame is abandoned with no dout_vld.
- Length lookup, from link_id[5:4]:
  - 00 -> 128
  - 01 -> 1088
  - 10 -> 4160
  - 11 -> cfg_len
  - link_id[3:0] is ignored for length.
- State IDLE:
  - din_vld loads len_r = lookup, rem_r = len_r, off_r = 0, and moves to RUN next cycle.
  - request in IDLE is ignored.
- State RUN, on request=1: the next cycle is a beat, with all outputs registered (latency 1):
  - wen = 1 and id_offset = off_r.
  - enable = all ones if rem_r >= LANES, else (1<<rem_r)-1.
  - Then off_r += LANES and rem_r -= min(rem_r, LANES), saturating at 0.
  - With request held high, a beat is issued every cycle. With request=0, wen=0 and enable/id_offset hold their last value.
- Last beat (rem_r <= LANES before the beat):
  - dout_vld pulses in the cycle after that beat's wen.
  - If the pending slot is valid, the pending frame loads on that same cycle and RUN continues with no bubble; the pending slot clears.
  - Otherwise the block returns to IDLE.
- Zero length (cfg_len=0 in mode 11): no wen beats; dout_vld pulses 2 cycles after the accepting din_vld.
- din_vld in RUN:
  - If the pending slot is empty, the looked-up length is stored there.
  - If the slot is full, the descriptor is dropped and ovf_err is set (sticky until rst).
  - din_vld arriving in the same cycle as the last-beat request goes to pending and is used for the next frame.
- busy = (state==RUN) | pending_valid, registered.
- Arithmetic: rem_r and len_r are LEN_W bits. off_r is OFF_W bits; with OFF_W >= LEN_W and the 4160 maximum it cannot overflow.

Decomposition:
- Package turbo_len_pkg holds:
  - length constants LEN_MODE0=128, LEN_MODE1=1088, LEN_MODE2=4160;
  - the mode encoding for link_id[5:4];
  - the state enum {IDLE, RUN}.
- One sub-module, turbo_len_lut: combinational link_id/cfg_len -> length, reusable by other interleaver stages.

Test Plan (LANES=16):
- rst, then din_vld with link_id=0x00 and request held -> 8 wen beats, enable=0xFFFF, id_offset 0,16,...,112; dout_vld the cycle after the 8th beat; busy falls with dout_vld.
- link_id=0x30, cfg_len=20, request held -> beat 1: 0xFFFF at offset 0; beat 2: 0x000F at offset 16; dout_vld; 2 beats total.
- link_id=0x10 (1088), request toggled 1/0 -> exactly 68 wen beats, each only in the cycle after a request=1, with no gaps skipped in id_offset. While request=0, enable holds its last value. Then a second din_vld with link_id=0x20 during RUN -> after the first dout_vld, the second frame starts with no bubble: 260 beats, offset starts at 0.
- Two extra din_vld pulses during RUN with the pending slot full -> the second pulse is dropped; ovf_err=1 and stays 1; only 2 frames complete.
- cfg_len=0 in mode 11 -> no wen; dout_vld 2 cycles after din_vld. Then rst mid-frame of link_id=0x20 -> next cycle all outputs are 0 and no dout_vld; a fresh frame then runs correctly from offset 0.
